hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the execute-stage flush into the ID/EX pipeline register, and the fetch/decode stalls.
- Consumes the ID/EX outputs Rs_E, Rt_E, WriteReg_E and MemtoReg_E, and produces the EX and decode forwarding selects.
- Tracks occupancy of the multi-cycle mult/div unit, and keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Hazard controller for the 5-stage MIPS core. Produces EX and
//            decode forwarding selects, fetch/decode stalls and the ID/EX
//            flush, tracks HI/LO unit occupancy and keeps saturating
//            stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           Rs_D,
  input  logic [4:0]           Rt_D,
  input  logic                 Branch_D,
  input  logic                 MulDiv_D,
  input  logic [4:0]           Rs_E,
  input  logic [4:0]           Rt_E,
  input  logic [4:0]           WriteReg_E,
  input  logic [4:0]           WriteReg_M,
  input  logic [4:0]           WriteReg_W,
  input  logic                 RegWrite_E,
  input  logic                 RegWrite_M,
  input  logic                 RegWrite_W,
  input  logic                 MemtoReg_E,
  input  logic                 MemtoReg_M,
  input  logic                 MulDivStart_E,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushE,
  output logic                 ForwardAD,
  output logic                 ForwardBD,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 MulDivBusy,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam int                    c_MD_W      = $clog2(MULDIV_LATENCY) + 1;
  localparam logic [c_MD_W-1:0]     c_MD_RELOAD = c_MD_W'(MULDIV_LATENCY - 1);
  localparam logic [c_MD_W-1:0]     c_MD_ONE    = c_MD_W'(1);
  localparam logic [CNT_WIDTH-1:0]  c_PERF_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  c_PERF_ONE  = CNT_WIDTH'(1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_BUSY = 1'b1;

  // A destination matches a source only when it is a real register ($0 never hazards)
  function automatic logic hit(input logic [4:0] dest, input logic [4:0] src);
    return (dest != 5'd0) && (dest == src);
  endfunction

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [c_MD_W-1:0]    r_md_cnt;
  logic [c_MD_W-1:0]    w_md_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;
  logic                 w_lwstall;
  logic                 w_branchstall;
  logic                 w_mdstall;
  logic                 w_hazard;

  // EX operand forwarding: M stage wins over W stage; all zero while in reset
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      if (RegWrite_M && hit(WriteReg_M, Rs_E))      ForwardAE = 2'b10;
      else if (RegWrite_W && hit(WriteReg_W, Rs_E)) ForwardAE = 2'b01;
      if (RegWrite_M && hit(WriteReg_M, Rt_E))      ForwardBE = 2'b10;
      else if (RegWrite_W && hit(WriteReg_W, Rt_E)) ForwardBE = 2'b01;
    end
  end

  // Decode-comparator forwarding from ALUOut_M
  always_comb begin
    ForwardAD = rst_n && RegWrite_M && hit(WriteReg_M, Rs_D);
    ForwardBD = rst_n && RegWrite_M && hit(WriteReg_M, Rt_D);
  end

  // Stall sources OR together; reset forces a bubble into ID/EX and no stalls
  always_comb begin
    w_lwstall     = MemtoReg_E && (hit(Rt_E, Rs_D) || hit(Rt_E, Rt_D));
    w_branchstall = Branch_D &&
                    ((RegWrite_E && (hit(WriteReg_E, Rs_D) || hit(WriteReg_E, Rt_D))) ||
                     (MemtoReg_M && (hit(WriteReg_M, Rs_D) || hit(WriteReg_M, Rt_D))));
    w_mdstall     = MulDiv_D && MulDivBusy;
    w_hazard      = w_lwstall || w_branchstall || w_mdstall;
    StallF        = rst_n && w_hazard;
    StallD        = rst_n && w_hazard;
    FlushE        = !rst_n || w_hazard;
  end

  // HI/LO occupancy state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // HI/LO next state: a new start always reloads, even while already busy
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    case (r_state)
      c_IDLE: begin
        if (MulDivStart_E) begin
          w_state_nxt  = c_BUSY;
          w_md_cnt_nxt = c_MD_RELOAD;
        end
      end
      c_BUSY: begin
        if (MulDivStart_E) begin
          w_md_cnt_nxt = c_MD_RELOAD;
        end else if (r_md_cnt != '0) begin
          w_md_cnt_nxt = r_md_cnt - c_MD_ONE;
        end else begin
          w_state_nxt = c_IDLE;
        end
      end
      default: begin
        w_state_nxt  = c_IDLE;
        w_md_cnt_nxt = '0;
      end
    endcase
  end

  // HI/LO busy flag decoded from the registered state
  always_comb begin
    MulDivBusy = (r_state == c_BUSY);
  end

  // Saturating performance counters; cleared and frozen during reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD && (r_stall_cnt != c_PERF_MAX)) r_stall_cnt <= r_stall_cnt + c_PERF_ONE;
      if (FlushE && (r_flush_cnt != c_PERF_MAX)) r_flush_cnt <= r_flush_cnt + c_PERF_ONE;
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl: directed scenarios followed
//            by randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int c_LAT  = 4;
  localparam int c_CW   = 4;
  localparam int c_SAT  = (1 << c_CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic            Branch_D, MulDiv_D, RegWrite_E, RegWrite_M, RegWrite_W;
  logic            MemtoReg_E, MemtoReg_M, MulDivStart_E;
  logic            StallF, StallD, FlushE, ForwardAD, ForwardBD, MulDivBusy;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [c_CW-1:0] StallCount, FlushCount;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: busy cycles remaining and event totals
  int m_busy_left = 0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_ctrl #(.MULDIV_LATENCY(c_LAT), .CNT_WIDTH(c_CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Branch_D(Branch_D), .MulDiv_D(MulDiv_D),
    .Rs_E(Rs_E), .Rt_E(Rt_E),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M), .MulDivStart_E(MulDivStart_E),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MulDivBusy(MulDivBusy), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Does a nonzero destination name either source register
  function automatic bit names(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return (d != 5'd0) && (d == a || d == b);
  endfunction

  function automatic logic [1:0] ex_sel(input logic [4:0] src);
    if (!rst_n) return 2'b00;
    if (RegWrite_M && names(WriteReg_M, src, src)) return 2'b10;
    if (RegWrite_W && names(WriteReg_W, src, src)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    rst_n = 1'b1;
    {Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W} = '0;
    {Branch_D, MulDiv_D, RegWrite_E, RegWrite_M, RegWrite_W} = '0;
    {MemtoReg_E, MemtoReg_M, MulDivStart_E} = '0;
  endtask

  // One clock: compare every output against the model at negedge, then advance the model
  task automatic cycle();
    bit busy, hz;
    @(negedge clk);
    busy = (m_busy_left > 0);
    hz = rst_n && ((MemtoReg_E && names(Rt_E, Rs_D, Rt_D)) ||
                   (Branch_D && ((RegWrite_E && names(WriteReg_E, Rs_D, Rt_D)) ||
                                 (MemtoReg_M && names(WriteReg_M, Rs_D, Rt_D)))) ||
                   (MulDiv_D && busy));
    check("StallF", 32'(StallF), 32'(hz));
    check("StallD", 32'(StallD), 32'(hz));
    check("FlushE", 32'(FlushE), 32'(!rst_n || hz));
    check("ForwardAE", 32'(ForwardAE), 32'(ex_sel(Rs_E)));
    check("ForwardBE", 32'(ForwardBE), 32'(ex_sel(Rt_E)));
    check("ForwardAD", 32'(ForwardAD), 32'(rst_n && RegWrite_M && names(WriteReg_M, Rs_D, Rs_D)));
    check("ForwardBD", 32'(ForwardBD), 32'(rst_n && RegWrite_M && names(WriteReg_M, Rt_D, Rt_D)));
    check("MulDivBusy", 32'(MulDivBusy), 32'(busy));
    check("StallCount", 32'(StallCount), 32'(m_stall));
    check("FlushCount", 32'(FlushCount), 32'(m_flush));
    @(posedge clk);
    if (!rst_n) begin
      m_busy_left = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (hz && m_stall < c_SAT) m_stall++;
      if (hz && m_flush < c_SAT) m_flush++;
      if (MulDivStart_E) m_busy_left = c_LAT;
      else if (m_busy_left > 0) m_busy_left--;
    end
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset: outputs forced even with matching hazards present
    RegWrite_M = 1'b1; WriteReg_M = 5'd5; Rs_E = 5'd5; Rs_D = 5'd5;
    MemtoReg_E = 1'b1; Rt_E = 5'd5;
    #2;
    check("rst_fwdAE", 32'(ForwardAE), 32'd0);
    check("rst_flushE", 32'(FlushE), 32'd1);
    check("rst_stallD", 32'(StallD), 32'd0);
    check("rst_busy", 32'(MulDivBusy), 32'd0);
    check("rst_stallcnt", 32'(StallCount), 32'd0);
    cycle();

    // Forward priority
    idle();
    RegWrite_M = 1'b1; RegWrite_W = 1'b1; WriteReg_M = 5'd5; WriteReg_W = 5'd5; Rs_E = 5'd5; Rt_E = 5'd5;
    #2; check("fwd_m_wins", 32'(ForwardAE), 32'd2); check("fwd_m_wins_b", 32'(ForwardBE), 32'd2);
    cycle();
    RegWrite_M = 1'b0;
    #2; check("fwd_w", 32'(ForwardAE), 32'd1);
    cycle();
    Rs_E = 5'd0; Rt_E = 5'd0; WriteReg_M = 5'd0; WriteReg_W = 5'd0; RegWrite_M = 1'b1;
    #2; check("fwd_r0", 32'(ForwardAE), 32'd0);
    cycle();

    // Load-use: one stall cycle
    idle();
    MemtoReg_E = 1'b1; Rt_E = 5'd8; Rs_D = 5'd8;
    #2; check("lw_stall", 32'(StallD), 32'd1);
    cycle();
    idle();
    #2; check("lw_release", 32'(StallD), 32'd0);
    check("lw_stallcnt", 32'(StallCount), 32'd1);
    check("lw_flushcnt", 32'(FlushCount), 32'd1);
    cycle();

    // Branch hazard then decode forwarding
    Branch_D = 1'b1; Rt_D = 5'd9; RegWrite_E = 1'b1; WriteReg_E = 5'd9;
    #2; check("br_stall", 32'(StallD), 32'd1);
    cycle();
    RegWrite_E = 1'b0; WriteReg_E = 5'd0; RegWrite_M = 1'b1; WriteReg_M = 5'd9;
    #2; check("br_nostall", 32'(StallD), 32'd0); check("br_fwdBD", 32'(ForwardBD), 32'd1);
    cycle();

    // HI/LO busy window with decode mult held
    idle();
    MulDivStart_E = 1'b1; MulDiv_D = 1'b1;
    #2; check("md_same_cycle", 32'(StallD), 32'd0);
    cycle();
    MulDivStart_E = 1'b0;
    for (int k = 0; k < c_LAT; k++) begin
      #2; check("md_busy", 32'(MulDivBusy), 32'd1); check("md_stall", 32'(StallD), 32'd1);
      cycle();
    end
    #2; check("md_done", 32'(MulDivBusy), 32'd0); check("md_release", 32'(StallD), 32'd0);
    check("md_stallcnt", 32'(StallCount), 32'd6);
    cycle();

    // Reset in the middle of a busy window
    idle();
    MulDivStart_E = 1'b1;
    cycle();
    MulDivStart_E = 1'b0;
    cycle();
    rst_n = 1'b0;
    #2; check("rb_busy_pre", 32'(MulDivBusy), 32'd1); check("rb_flush", 32'(FlushE), 32'd1);
    cycle();
    #2; check("rb_busy_post", 32'(MulDivBusy), 32'd0); check("rb_cnt", 32'(StallCount), 32'd0);
    check("rb_fcnt", 32'(FlushCount), 32'd0); check("rb_flush2", 32'(FlushE), 32'd1);
    cycle();
    rst_n = 1'b1; MulDiv_D = 1'b1;
    repeat (3) begin
      #2; check("rb_nostall", 32'(StallD), 32'd0);
      cycle();
    end

    // Counter saturation
    idle();
    MemtoReg_E = 1'b1; Rt_E = 5'd8; Rs_D = 5'd8;
    repeat (20) cycle();
    idle();
    #2; check("sat_stall", 32'(StallCount), 32'(c_SAT)); check("sat_flush", 32'(FlushCount), 32'(c_SAT));
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      rst_n         = ($urandom_range(0, 24) != 0);
      Rs_D          = 5'($urandom_range(0, 3));
      Rt_D          = 5'($urandom_range(0, 3));
      Rs_E          = 5'($urandom_range(0, 3));
      Rt_E          = 5'($urandom_range(0, 3));
      WriteReg_E    = 5'($urandom_range(0, 3));
      WriteReg_M    = 5'($urandom_range(0, 3));
      WriteReg_W    = 5'($urandom_range(0, 3));
      Branch_D      = 1'($urandom_range(0, 1));
      MulDiv_D      = 1'($urandom_range(0, 1));
      RegWrite_E    = 1'($urandom_range(0, 1));
      RegWrite_M    = 1'($urandom_range(0, 1));
      RegWrite_W    = 1'($urandom_range(0, 1));
      MemtoReg_E    = ($urandom_range(0, 3) == 0);
      MemtoReg_M    = ($urandom_range(0, 3) == 0);
      MulDivStart_E = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
